// File: rtl/serial_priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_priority_encoder_pkg
// Description : Shared widths, FSM state encoding and bit-count helper for the
//               serial priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_priority_encoder_pkg;

  localparam int VEC_W = 32;
  localparam int IDX_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder_32.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_32
// Description : Combinational 32-bit priority encoder; returns the index of the
//               lowest (msb_first_i=0) or highest (msb_first_i=1) set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_32
  import serial_priority_encoder_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  input  logic             msb_first_i,
  output logic [IDX_W-1:0] idx_o
);

  // Later loop iterations overwrite earlier ones, so the scan direction
  // decides which set bit wins. An all-zero vector yields index 0.
  always_comb begin
    idx_o = '0;
    if (msb_first_i) begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : serial_priority_encoder
// Description : Captures a multi-hot vector and emits the index of each set bit,
//               one per accepted output beat, in a configurable scan order.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_priority_encoder
  import serial_priority_encoder_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  state_t             state_q;
  logic [VEC_W-1:0]   pending_q;
  logic [VEC_W-1:0]   pending_d;
  logic [IDX_W-1:0]   out_idx_q;
  logic               out_last_q;
  logic [IDX_W-1:0]   w_next_idx;
  logic               w_in_fire;
  logic               w_out_fire;
  logic [VEC_W-1:0]   w_clr_mask;

  assign in_ready   = rst_n && (state_q == IDLE);
  assign out_valid  = (state_q == SCAN);
  assign busy       = (state_q == SCAN);
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;

  assign w_in_fire  = in_valid && (state_q == IDLE);
  assign w_out_fire = out_valid && out_ready;
  assign w_clr_mask = ~(VEC_W'(1) << out_idx_q);

  always_comb begin
    pending_d = pending_q;
    if (w_in_fire) begin
      pending_d = in_vec;
    end else if (w_out_fire) begin
      pending_d = pending_q & w_clr_mask;
    end
  end

  // The index for the next cycle is encoded from the next pending value and
  // registered, so out_idx/out_last come straight from flops.
  priority_encoder_32 u_enc (
    .vec_i       (pending_d),
    .msb_first_i (MSB_FIRST),
    .idx_o       (w_next_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      out_idx_q  <= w_next_idx;
      out_last_q <= is_onehot(pending_d);
      case (state_q)
        IDLE: if (w_in_fire && (in_vec != '0)) state_q <= SCAN;
        SCAN: if (w_out_fire && out_last_q)    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_priority_encoder.md
SERIAL_PRIORITY_ENCODER -- requirements
Module: serial_priority_encoder

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0, scan order: 0 = lowest set bit first, 1 = highest set bit first.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, in_vec is presented.
REQ-005 The block SHALL have port in_ready, output, 1, the block accepts in_vec this cycle.
REQ-006 The block SHALL have port in_vec, input, 32, multi-hot request vector.
REQ-007 The block SHALL have port out_valid, output, 1, out_idx and out_last are valid.
REQ-008 The block SHALL have port out_ready, input, 1, the consumer takes the current index.
REQ-009 The block SHALL have port out_idx, output, 5, binary index of the selected set bit.
REQ-010 The block SHALL have port out_last, output, 1, out_idx is the final set bit of the captured vector.
REQ-011 The block SHALL have port busy, output, 1, a captured vector is still being emitted.

Function
REQ-012 The block SHALL implement two states, IDLE and SCAN, with a 32-bit pending register.
REQ-013 in_ready SHALL be 1 in IDLE and 0 in SCAN, decoded from state only.
REQ-014 An input handshake (in_valid & in_ready) SHALL load pending <= in_vec and move to SCAN if in_vec != 0.
REQ-015 An input handshake with in_vec == 0 SHALL be consumed with the block remaining in IDLE and no output beat.
REQ-016 out_valid SHALL be 1 exactly while in SCAN; first valid index is the cycle after acceptance (latency 1).
REQ-017 out_idx SHALL be the index of the lowest set bit of pending (highest if MSB_FIRST=1), derived from registers only, with no combinational path from in_* to out_*.
REQ-018 out_last SHALL be 1 when pending has exactly one bit set.
REQ-019 An output handshake (out_valid & out_ready) SHALL clear the bit at out_idx in pending.
REQ-020 An output handshake with out_last=1 SHALL return the state to IDLE, so in_ready is 1 the following cycle.
REQ-021 While out_valid=1 and out_ready=0, out_idx, out_last and pending SHALL hold stable.
REQ-022 in_vec and in_valid SHALL be ignored in SCAN.
REQ-023 Throughput SHALL be one index per cycle: a vector with N set bits, out_ready held 1, occupies SCAN for exactly N cycles.
REQ-024 busy SHALL equal (state == SCAN).
REQ-025 Every index SHALL be emitted exactly once per captured vector, in strict scan order, with no duplicates or omissions, including bit 0 and bit 31.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, busy=0.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-028 Reset asserted mid-SCAN SHALL discard all remaining pending bits; no residual beats after release.

Structure
REQ-029 A shared package SHALL hold VEC_W=32, IDX_W=5 and the state enumeration {IDLE, SCAN}.
REQ-030 Index selection SHALL live in one combinational sub-module, priority_encoder_32 (32-bit in, 5-bit index, direction input), instantiated once.

Verification
REQ-031 in_vec=32'h0000_0001, out_ready=1 -> one beat idx=0, last=1; in_ready=1 the next cycle.
REQ-032 in_vec=32'h8000_0011, out_ready=1 -> idx 0,4,31 on consecutive cycles, last=1 only on 31.
REQ-033 in_vec=32'hFFFF_FFFF, out_ready toggling 1/0 -> 32 beats idx 0..31 in order; idx stable during every stall.
REQ-034 in_vec=32'h0 accepted -> out_valid stays 0; in_ready stays 1; busy stays 0.
REQ-035 MSB_FIRST=1, in_vec=32'h8000_0011 -> idx 31,4,0; last=1 on 0.
REQ-036 in_vec=32'h0000_F000, reset pulsed after 2 beats -> out_valid=0 immediately; after release in_ready=1, no further beats until a new vector is accepted.
